// File: rtl/axi_lite_master_cmd_if.sv
// AXI4-Lite bus between a single master and a single slave.
//
// Handshake rule for every channel (AW, W, B, AR, R): a beat transfers on a
// rising clock edge where VALID and READY are both high. Once raised, VALID
// stays high and the payload stays stable until that edge; READY may be
// raised or lowered freely and never depends on VALID being low.
//
// Modports:
//   master : drives AW*, W*, AR* payload/VALID and BREADY/RREADY.
//   slave  : drives AWREADY, WREADY, ARREADY and the B/R payload/VALID.
interface axi_lite_master_cmd_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWVALID, input AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARVALID, input ARREADY,
      input RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWVALID, output AWREADY,
      input WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master. Accepts one register command from
// local logic, runs it as an AXI-Lite write (AW+W issued together, then B)
// or read (AR then R), and returns data/response to the requester.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   CMD_ADDR/WDATA/WSTRB    command payload
//   CMD_WRITE               1 = write, 0 = read
//   CMD_VALID/CMD_READY     command handshake (CMD_READY high only in idle)
//   RSP_RDATA/RESP/WRITE    completed-command result, held until consumed
//   RSP_VALID/RSP_READY     response handshake
//   TIMEOUT                 sticky: some AXI handshake waited TIMEOUT_CYCLES
//   axi                     AXI4-Lite master bus (all outputs registered)
//   STATE_DBG               current FSM state for observation
module axi_lite_master_cmd #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
   input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
   input  logic                    CMD_WRITE,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   output logic [DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [1:0]              RSP_RESP,
   output logic                    RSP_WRITE,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic                    TIMEOUT,
   axi_lite_master_cmd_if.master   axi,
   output logic [2:0]              STATE_DBG
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_WRESP = 3'd2,
      ST_READ  = 3'd3,
      ST_RDATA = 3'd4,
      ST_RSP   = 3'd5
   } state_t;

   // Counter wide enough to hold TIMEOUT_CYCLES itself (it saturates there).
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

   state_t        state;
   logic [CW-1:0] tmo_cnt;
   logic          aw_fin;
   logic          w_fin;
   logic          wait_st;
   logic          exit_now;

   assign CMD_READY = (state == ST_IDLE) && !RESET;
   assign STATE_DBG = state;

   // A channel is finished once its VALID has dropped or it handshakes now.
   assign aw_fin = !axi.AWVALID || axi.AWREADY;
   assign w_fin  = !axi.WVALID  || axi.WREADY;

   always_comb begin
      wait_st  = 1'b0;
      exit_now = 1'b0;
      case (state)
         ST_WRITE: begin wait_st = 1'b1; exit_now = aw_fin && w_fin;                 end
         ST_WRESP: begin wait_st = 1'b1; exit_now = axi.BVALID && axi.BREADY;         end
         ST_READ:  begin wait_st = 1'b1; exit_now = axi.ARVALID && axi.ARREADY;       end
         ST_RDATA: begin wait_st = 1'b1; exit_now = axi.RVALID && axi.RREADY;         end
         default:  begin wait_st = 1'b0; exit_now = 1'b0;                             end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         TIMEOUT     <= 1'b0;
         axi.AWADDR  <= '0;
         axi.AWVALID <= 1'b0;
         axi.WDATA   <= '0;
         axi.WSTRB   <= '0;
         axi.WVALID  <= 1'b0;
         axi.BREADY  <= 1'b0;
         axi.ARADDR  <= '0;
         axi.ARVALID <= 1'b0;
         axi.RREADY  <= 1'b0;
         RSP_RDATA   <= '0;
         RSP_RESP    <= 2'd0;
         RSP_WRITE   <= 1'b0;
         RSP_VALID   <= 1'b0;
      end else begin
         // Timeout only observes; the transaction keeps waiting regardless.
         if (!wait_st || exit_now) begin
            tmo_cnt <= '0;
         end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt != TO_LIM)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TO_LIM - 1'b1) TIMEOUT <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  if (CMD_WRITE) begin
                     axi.AWADDR  <= CMD_ADDR;
                     axi.WDATA   <= CMD_WDATA;
                     axi.WSTRB   <= CMD_WSTRB;
                     axi.AWVALID <= 1'b1;
                     axi.WVALID  <= 1'b1;
                     state       <= ST_WRITE;
                  end else begin
                     axi.ARADDR  <= CMD_ADDR;
                     axi.ARVALID <= 1'b1;
                     state       <= ST_READ;
                  end
               end
            end
            ST_WRITE: begin
               // AW and W complete independently, possibly on the same edge.
               if (axi.AWREADY) axi.AWVALID <= 1'b0;
               if (axi.WREADY)  axi.WVALID  <= 1'b0;
               if (aw_fin && w_fin) begin
                  axi.BREADY <= 1'b1;
                  state      <= ST_WRESP;
               end
            end
            ST_WRESP: begin
               if (axi.BVALID) begin
                  axi.BREADY <= 1'b0;
                  RSP_RDATA  <= '0;
                  RSP_RESP   <= axi.BRESP;
                  RSP_WRITE  <= 1'b1;
                  RSP_VALID  <= 1'b1;
                  state      <= ST_RSP;
               end
            end
            ST_READ: begin
               if (axi.ARREADY) begin
                  axi.ARVALID <= 1'b0;
                  axi.RREADY  <= 1'b1;
                  state       <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (axi.RVALID) begin
                  axi.RREADY <= 1'b0;
                  RSP_RDATA  <= axi.RDATA;
                  RSP_RESP   <= axi.RRESP;
                  RSP_WRITE  <= 1'b0;
                  RSP_VALID  <= 1'b1;
                  state      <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
